// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator.
// Per-channel divider with OFF/ON/BLINK/PWM output modes.
module led_pattern_gen #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 25,
  parameter int DEFAULT_DIV  = 2**24-1,
  parameter int DEFAULT_MODE = 2
) (
  input  logic              clk0_1,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [3:0]        cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [7:0]        cfg_duty,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] led_out,
  output logic [NUM_CH-1:0] tick_out
);

  localparam logic [1:0] M_OFF   = 2'd0;
  localparam logic [1:0] M_ON    = 2'd1;
  localparam logic [1:0] M_BLINK = 2'd2;
  localparam logic [1:0] M_PWM   = 2'd3;

  localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);
  localparam logic [1:0]       MODE_RST = 2'(DEFAULT_MODE);

  logic [CNT_W-1:0] cnt   [NUM_CH];
  logic [CNT_W-1:0] div   [NUM_CH];
  logic [1:0]       mode  [NUM_CH];
  logic [7:0]       duty  [NUM_CH];
  logic [7:0]       phase [NUM_CH];
  logic [NUM_CH-1:0] tgl;
  logic [NUM_CH-1:0] led_nxt;

  logic wr_acc;
  logic wr_hit;

  assign wr_acc = cfg_valid & cfg_ready;
  assign wr_hit = wr_acc && ({28'd0, cfg_ch} < NUM_CH);

  // LED level implied by each channel's current state
  always_comb begin
    led_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      case (mode[i])
        M_OFF:   led_nxt[i] = 1'b0;
        M_ON:    led_nxt[i] = 1'b1;
        M_BLINK: led_nxt[i] = tgl[i];
        M_PWM:   led_nxt[i] = (phase[i] < duty[i]);
        default: led_nxt[i] = 1'b0;
      endcase
    end
  end

  // Per-channel divider, wrap tick and config load
  always_ff @(posedge clk0_1) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]   <= '0;
        div[i]   <= DIV_RST;
        mode[i]  <= MODE_RST;
        duty[i]  <= '0;
        phase[i] <= '0;
      end
      tgl      <= '0;
      tick_out <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_hit && cfg_ch == 4'(i)) begin
          cnt[i]      <= '0;
          div[i]      <= cfg_div;
          mode[i]     <= cfg_mode;
          duty[i]     <= cfg_duty;
          phase[i]    <= '0;
          tgl[i]      <= 1'b0;
          tick_out[i] <= 1'b0;
        end else if (cnt[i] == div[i]) begin
          cnt[i]      <= '0;
          phase[i]    <= phase[i] + 8'd1;
          tgl[i]      <= ~tgl[i];
          tick_out[i] <= 1'b1;
        end else begin
          cnt[i]      <= cnt[i] + CNT_W'(1);
          tick_out[i] <= 1'b0;
        end
      end
    end
  end

  // Handshake, error pulse and registered LED drive
  always_ff @(posedge clk0_1) begin
    if (!rst) begin
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
      led_out   <= '0;
    end else begin
      cfg_ready <= ~wr_acc;
      cfg_err   <= wr_acc & ~wr_hit;
      led_out   <= led_nxt;
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen.
// Reference tracks each channel by restart edge and wrap arithmetic.
module tb_led_pattern_gen;

  localparam int NCH = 4;
  localparam int CW  = 25;
  localparam int DDIV  = 3;
  localparam int DMODE = 2;

  logic           clk0_1 = 1'b0;
  logic           rst = 1'b0;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [3:0]     cfg_ch = '0;
  logic [1:0]     cfg_mode = '0;
  logic [CW-1:0]  cfg_div = '0;
  logic [7:0]     cfg_duty = '0;
  logic           cfg_err;
  logic [NCH-1:0] led_out;
  logic [NCH-1:0] tick_out;

  led_pattern_gen #(
    .NUM_CH(NCH),
    .CNT_W(CW),
    .DEFAULT_DIV(DDIV),
    .DEFAULT_MODE(DMODE)
  ) dut (
    .clk0_1(clk0_1),
    .rst(rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode),
    .cfg_div(cfg_div),
    .cfg_duty(cfg_duty),
    .cfg_err(cfg_err),
    .led_out(led_out),
    .tick_out(tick_out)
  );

  always #5 clk0_1 = ~clk0_1;

  int n_assert = 0;
  int n_fail = 0;

  // model: channel restarted at edge s[i] with divide d[i]
  int e = 0;
  int s  [NCH];
  int d  [NCH];
  int md [NCH];
  int dt [NCH];
  bit m_ready = 0;
  logic [NCH-1:0] x_led = '0;
  logic [NCH-1:0] x_tick = '0;
  logic x_ready = 0;
  logic x_err = 0;

  function automatic bit led_fn(int i, int at);
    int w;
    w = (at - s[i]) / (d[i] + 1);
    case (md[i])
      0: return 1'b0;
      1: return 1'b1;
      2: return bit'(w % 2);
      default: return (w % 256) < dt[i];
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%h exp=%h edge=%0d", tag, obs, exp, e);
    end
  endtask

  task automatic step(bit rn, bit v, logic [3:0] ch,
                      logic [1:0] m, logic [CW-1:0] dv,
                      logic [7:0] dy);
    bit acc;
    rst = rn;
    cfg_valid = v;
    cfg_ch = ch;
    cfg_mode = m;
    cfg_div = dv;
    cfg_duty = dy;
    @(posedge clk0_1);
    e++;
    if (!rn) begin
      for (int i = 0; i < NCH; i++) begin
        s[i] = e; d[i] = DDIV; md[i] = DMODE; dt[i] = 0;
      end
      x_led = '0; x_tick = '0; x_err = 0; m_ready = 0;
    end else begin
      for (int i = 0; i < NCH; i++) x_led[i] = led_fn(i, e - 1);
      acc = v && m_ready;
      x_err = acc && (ch >= NCH);
      if (acc && ch < NCH) begin
        s[ch] = e; d[ch] = int'(dv);
        md[ch] = int'(m); dt[ch] = int'(dy);
      end
      for (int i = 0; i < NCH; i++)
        x_tick[i] = (e > s[i]) && ((e - s[i]) % (d[i] + 1) == 0);
      m_ready = !acc;
    end
    x_ready = m_ready;
    #1;
    chk("led_out", 32'(led_out), 32'(x_led));
    chk("tick_out", 32'(tick_out), 32'(x_tick));
    chk("cfg_ready", 32'(cfg_ready), 32'(x_ready));
    chk("cfg_err", 32'(cfg_err), 32'(x_err));
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 3, 0, 9);
    idle(20);
    // PWM on ch1, div 0, duty 64
    step(1, 1, 1, 3, 0, 64);
    idle(520);
    // ON then OFF back-to-back on ch2
    step(1, 1, 2, 1, 3, 0);
    step(1, 1, 2, 0, 3, 0);
    step(1, 1, 2, 0, 3, 0);
    idle(6);
    // out-of-range channel
    step(1, 1, 7, 1, 0, 255);
    idle(6);
    step(1, 1, 15, 1, 0, 255);
    idle(3);
    // write ch0 exactly on its wrap edge
    for (int k = 0; k < 8; k++)
      if (((e + 1 - s[0]) % (d[0] + 1)) != 0) idle(1);
    step(1, 1, 0, 2, 5, 0);
    idle(15);
    // reset during a write on ch3's wrap edge
    for (int k = 0; k < 8; k++)
      if (((e + 1 - s[3]) % (d[3] + 1)) != 0) idle(1);
    step(0, 1, 3, 1, 0, 0);
    idle(24);
    // randomized traffic
    for (int k = 0; k < 1500; k++) begin
      bit rn, v;
      logic [3:0] ch;
      logic [7:0] dy;
      rn = ($urandom_range(0, 199) != 0);
      v = ($urandom_range(0, 3) == 0);
      ch = 4'($urandom_range(0, 5));
      if ($urandom_range(0, 9) == 0) ch = 4'($urandom_range(4, 15));
      dy = 8'($urandom);
      if ($urandom_range(0, 7) == 0) dy = 8'd0;
      if ($urandom_range(0, 7) == 0) dy = 8'd255;
      step(rn, v, ch, 2'($urandom), CW'($urandom_range(0, 5)), dy);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
